// File: rtl/spinet_spi_port.sv
// spinet_spi_port: SPI slave bridging an external host to a spinet ring node
`timescale 1ns/1ps
module spinet_spi_port #(
    parameter logic [2:0] ADDR = 3'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sck,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        txrdy,
    output logic        rxrdy,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] sck_s, ss_s, mosi_s, live;
    logic sck_q, ss_q, armed, from_rx;
    logic [15:0] out_sr, cap_sr, rx_buf;
    logic [4:0] cnt;
    logic sck_rise, sck_fall, ss_fall, ss_rise, drain, full, tx_load;
    assign sck_rise = sck_s[1] & ~sck_q;
    assign sck_fall = ~sck_s[1] & sck_q;
    // a transfer may only start once ss has been seen high after reset
    assign ss_fall = armed & ss_q & ~ss_s[1];
    assign ss_rise = ~ss_q & ss_s[1];
    assign drain = tx_valid & tx_ready;
    assign full = state == DONE && cnt == 5'd16;
    assign tx_load = full && cap_sr[15] && (txrdy || drain);
    assign miso = out_sr[15];
    assign tx_valid = ~txrdy;
    assign rx_ready = ~rxrdy & (state == IDLE);
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && ss_fall) ? SHIFT :
                   (state == SHIFT && ss_rise) ? DONE :
                   (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sck_s <= 2'b00;
            ss_s <= 2'b11;
            mosi_s <= 2'b00;
            sck_q <= 1'b0;
            ss_q <= 1'b1;
            live <= 2'b00;
            armed <= 1'b0;
            out_sr <= '0;
            cap_sr <= '0;
            cnt <= '0;
            from_rx <= 1'b0;
            rx_buf <= '0;
            rxrdy <= 1'b0;
            tx_data <= '0;
            txrdy <= 1'b1;
        end else begin
            state <= state_nx;
            sck_s <= {sck_s[0], sck};
            ss_s <= {ss_s[0], ss};
            mosi_s <= {mosi_s[0], mosi};
            sck_q <= sck_s[1];
            ss_q <= ss_s[1];
            live <= {live[0], 1'b1};
            armed <= armed | (live[1] & ss_s[1]);
            if (state == IDLE && ss_fall) begin
                out_sr <= rxrdy ? rx_buf : 16'h0000;
                from_rx <= rxrdy;
                cap_sr <= '0;
                cnt <= '0;
            end else if (state == SHIFT && !ss_rise) begin
                if (sck_rise) begin
                    cap_sr <= {cap_sr[14:0], mosi_s[1]};
                    cnt <= cnt + 5'(cnt != 5'd16);
                end
                if (sck_fall)
                    out_sr <= {out_sr[14:0], 1'b0};
            end else if (state == DONE) begin
                out_sr <= '0;
                cnt <= '0;
                from_rx <= 1'b0;
            end
            if (full && from_rx)
                rxrdy <= 1'b0;
            else if (rx_valid && rx_ready) begin
                rx_buf <= rx_data;
                rxrdy <= 1'b1;
            end
            // a same-cycle drain frees the slot so the new packet still lands
            if (tx_load) begin
                tx_data <= {cap_sr[15:11], ADDR, cap_sr[7:0]};
                txrdy <= 1'b0;
            end else if (drain)
                txrdy <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spinet_spi_port.sv
// tb_spinet_spi_port: directed and random SPI transfers checked against a packet-level model
`timescale 1ns/1ps
module tb_spinet_spi_port;
    localparam logic [2:0] A = 3'd3;
    logic clk = 0, resetn = 0, sck = 0, ss = 1, mosi = 0, tx_ready = 0, rx_valid = 0;
    logic [15:0] rx_data = 0;
    logic miso, txrdy, rxrdy, tx_valid, rx_ready;
    logic [15:0] tx_data;
    int passes = 0, checks = 0;
    logic m_txv = 0, m_rxv = 0;
    logic [15:0] m_tx = 0, m_rx = 0;

    spinet_spi_port #(.ADDR(A)) dut (
        .clk(clk), .resetn(resetn), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
        .txrdy(txrdy), .rxrdy(rxrdy), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    always #12.5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rxrdy"}, 16'(rxrdy), 16'(m_rxv));
        check({tag, "_rx_ready"}, 16'(rx_ready), 16'(!m_rxv));
        check({tag, "_txrdy"}, 16'(txrdy), 16'(!m_txv));
        check({tag, "_tx_valid"}, 16'(tx_valid), 16'(m_txv));
        if (m_txv) check({tag, "_tx_data"}, tx_data, m_tx);
    endtask

    task automatic xfer(input logic [15:0] d, input int n, output logic [15:0] got);
        got = '0;
        @(negedge clk);
        #5 ss = 0;
        #100;
        for (int i = 0; i < n; i++) begin
            mosi = d[15-i];
            #50 sck = 1;
            #45 got[15-i] = miso;
            #5 sck = 0;
        end
        #50 ss = 1;
        mosi = 0;
    endtask

    task automatic model_xfer(input logic [15:0] d, input int n, output logic [15:0] exp);
        exp = m_rxv ? m_rx : 16'h0000;
        if (n == 16) begin
            m_rxv = 0;
            if (d[15] && !m_txv) begin
                m_txv = 1;
                m_tx = {d[15:11], A, d[7:0]};
            end
        end
    endtask

    task automatic do_xfer(input logic [15:0] d, input int n, input string tag);
        logic [15:0] got, exp, m;
        xfer(d, n, got);
        model_xfer(d, n, exp);
        m = 16'hFFFF >> n;
        m = ~m;
        check({tag, "_miso"}, got & m, exp & m);
        repeat (12) @(negedge clk);
        check_state(tag);
    endtask

    task automatic offer(input logic [15:0] v);
        @(negedge clk);
        rx_valid = 1;
        rx_data = v;
        @(negedge clk);
        rx_valid = 0;
        if (!m_rxv) begin
            m_rxv = 1;
            m_rx = v;
        end
    endtask

    task automatic drain;
        @(negedge clk);
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        m_txv = 0;
        check("drain_txrdy", 16'(txrdy), 16'd1);
        check("drain_tx_valid", 16'(tx_valid), 16'd0);
    endtask

    initial begin
        logic [15:0] got, exp;
        int k, kd, n;
        repeat (3) @(negedge clk);
        check("rst_txrdy", 16'(txrdy), 16'd1);
        check("rst_rxrdy", 16'(rxrdy), 16'd0);
        check("rst_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_tx_data", tx_data, 16'h0000);
        check("rst_rx_ready", 16'(rx_ready), 16'd1);
        check("rst_miso", 16'(miso), 16'd0);
        resetn = 1;
        repeat (4) @(negedge clk);

        // host packet injected with this node's source address
        xfer(16'h8842, 16, got);
        model_xfer(16'h8842, 16, exp);
        check("inj_miso", got, exp);
        k = 0;
        while (k < 8 && !tx_valid) begin
            @(negedge clk);
            k++;
        end
        kd = k;
        check("inj_latency", 16'(k <= 5), 16'd1);
        check("inj_tx_data", tx_data, 16'h8B42);
        repeat (8) @(negedge clk);
        check_state("inj");

        offer(16'h8A55);
        check_state("rx_loaded");
        do_xfer(16'h0000, 16, "rx_read");

        do_xfer(16'h8001, 16, "tx_full_drop");
        drain();

        offer(16'h4C3A);
        do_xfer(16'h8FFF, 9, "abort9");
        do_xfer(16'h0000, 16, "reread");

        // drain and a new DONE load land on the same clock edge
        do_xfer(16'h8123, 16, "pre_sim");
        xfer(16'h8456, 16, got);
        repeat (kd - 1) @(negedge clk);
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
        m_tx = 16'h8356;
        check("sim_tx_data", tx_data, 16'h8356);
        check("sim_tx_valid", 16'(tx_valid), 16'd1);
        repeat (10) @(negedge clk);
        check_state("sim");

        // reset mid-transfer, host keeps ss low and keeps clocking
        offer(16'h7777);
        @(negedge clk);
        #5 ss = 0;
        #100;
        for (int i = 0; i < 5; i++) begin
            mosi = 1;
            #50 sck = 1;
            #50 sck = 0;
        end
        resetn = 0;
        m_txv = 0;
        m_rxv = 0;
        #1;
        check("mid_rst_txrdy", 16'(txrdy), 16'd1);
        check("mid_rst_rxrdy", 16'(rxrdy), 16'd0);
        check("mid_rst_tx_valid", 16'(tx_valid), 16'd0);
        check("mid_rst_tx_data", tx_data, 16'h0000);
        check("mid_rst_rx_ready", 16'(rx_ready), 16'd1);
        check("mid_rst_miso", 16'(miso), 16'd0);
        repeat (2) @(negedge clk);
        resetn = 1;
        for (int i = 0; i < 16; i++) begin
            mosi = 1;
            #50 sck = 1;
            #50 sck = 0;
        end
        #50 ss = 1;
        mosi = 0;
        repeat (12) @(negedge clk);
        check_state("post_rst_noload");
        do_xfer(16'h8842, 16, "post_rst");
        check("post_rst_data", tx_data, 16'h8B42);
        drain();

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(1) == 1) offer(16'($urandom));
            n = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 16;
            do_xfer(16'($urandom), n, "rnd");
            if (m_txv && $urandom_range(2) == 0) drain();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
